// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction-timer controller.
// State encoding, LFSR seed/taps and ARM hold length.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    REACT,
    SHOW,
    FALSE_START
  } state_t;

  localparam logic [14:0] LFSR_SEED  = 15'h0001;
  localparam logic [14:0] LFSR_TAPS  = 15'h6000;
  localparam int          ARM_CYCLES = 2;

  function automatic logic [14:0] lfsr_next(
    input logic [14:0] s
  );
    return {s[13:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running 15-bit Fibonacci LFSR (x^15 + x^14 + 1).
// Advances every clock; a nonzero seed keeps it out of the all-zero state.
module lfsr_gen
  import reaction_timer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [14:0] o_lfsr
);

  logic [14:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer game controller driving an external delay up-counter.
// Optional BEST_TIME_EN adds a Best_Time output tracking the fastest result.
module reaction_timer_ctrl
  import reaction_timer_pkg::*;
#(
  parameter int N        = 15,
  parameter int T_W      = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic           Clk,
  input  logic           Resetn,
  input  logic           Start,
  input  logic           Stop,
  output logic           Delay_En,
  output logic [N-1:0]   Delay_Value,
  input  logic           Delay_Done,
  output logic           Led,
  output logic [T_W-1:0] Reaction_Time,
  output logic           Result_Valid,
  output logic           False_Start
`ifdef BEST_TIME_EN
  ,
  output logic [T_W-1:0] Best_Time
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ARM_CYCLES + 1);

  state_t         r_state;
  state_t         w_next;
  logic           r_start_q;
  logic           r_stop_q;
  logic           w_start_rise;
  logic           w_stop_rise;
  logic [AW-1:0]  r_arm_cnt;
  logic           w_arm_last;
  logic [PW-1:0]  r_pre;
  logic           w_tick;
  logic [T_W-1:0] r_cnt;
  logic [T_W-1:0] w_cnt_inc;
  logic [14:0]    w_lfsr;
  logic [N-1:0]   w_dv;
  logic           w_enter_arm;
  logic           w_enter_show;
  logic           w_en;
  logic           w_led;
  logic           w_rv;
  logic           w_fs;

  lfsr_gen u_lfsr (
    .i_clk   (Clk),
    .i_rst_n (Resetn),
    .o_lfsr  (w_lfsr)
  );

  assign w_start_rise = Start & ~r_start_q;
  assign w_stop_rise  = Stop & ~r_stop_q;
  assign w_arm_last   = r_arm_cnt == AW'(ARM_CYCLES - 1);
  assign w_tick       = r_pre == PW'(TICK_DIV - 1);

  // Saturating increment; also feeds the value latched on Stop.
  assign w_cnt_inc = (w_tick && r_cnt != '1) ? r_cnt + T_W'(1) : r_cnt;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_start_q <= Start;
      r_stop_q  <= Stop;
      r_arm_cnt <= (r_state == ARM) ? r_arm_cnt + AW'(1) : '0;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:        if (w_start_rise) w_next = ARM;
      ARM:         if (w_arm_last) w_next = WAIT;
      WAIT: begin
        if (w_stop_rise)     w_next = FALSE_START;
        else if (Delay_Done) w_next = REACT;
      end
      REACT:       if (w_stop_rise) w_next = SHOW;
      SHOW:        if (w_start_rise) w_next = ARM;
      FALSE_START: if (w_start_rise) w_next = ARM;
      default:     w_next = IDLE;
    endcase
  end

  always_comb begin
    w_en         = 1'b0;
    w_led        = 1'b0;
    w_rv         = 1'b0;
    w_fs         = 1'b0;
    w_enter_arm  = (w_next == ARM) && (r_state != ARM);
    w_enter_show = (r_state == REACT) && (w_next == SHOW);
    w_dv         = w_lfsr[N-1:0];
    w_dv[N-1]    = 1'b1;
    unique case (1'b1)
      (w_next == WAIT):        w_en  = 1'b1;
      (w_next == REACT):       w_led = 1'b1;
      (w_next == SHOW):        w_rv  = 1'b1;
      (w_next == FALSE_START): w_fs  = 1'b1;
      default:                 w_en  = 1'b0;
    endcase
  end

  // Prescaler and tick counter are held at zero outside REACT.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (r_state != REACT) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_cnt <= w_cnt_inc;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      Delay_En      <= 1'b0;
      Delay_Value   <= '0;
      Led           <= 1'b0;
      Reaction_Time <= '0;
      Result_Valid  <= 1'b0;
      False_Start   <= 1'b0;
    end else begin
      Delay_En     <= w_en;
      Led          <= w_led;
      Result_Valid <= w_rv;
      False_Start  <= w_fs;
      if (w_enter_arm)  Delay_Value   <= w_dv;
      if (w_enter_show) Reaction_Time <= w_cnt_inc;
    end
  end

`ifdef BEST_TIME_EN
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      Best_Time <= '1;
    end else if (w_enter_show && (w_cnt_inc < Best_Time)) begin
      Best_Time <= w_cnt_inc;
    end
  end
`endif

endmodule
